// File: rtl/alu_pkg.sv
`default_nettype none
//==============================================================================
// Package : alu_pkg
// Brief   : Opcodes, command record and opcode legality check shared by the
//           ALU command engine and its datapath.
// Rev     : 1.0 - initial release
//==============================================================================
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } alu_cmd_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_4bit.sv
`default_nettype none
//==============================================================================
// Module : alu_4bit
// Brief  : Combinational 4-bit ALU: AND, OR, ADD, SUB, SLT with signed overflow.
// Rev    : 1.0 - initial release
//==============================================================================
module alu_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [2:0] Operation,
    output logic [3:0] Result,
    output logic       Zero,
    output logic       Overflow
);

    logic [3:0] w_b_eff;
    logic [3:0] w_sum;
    logic       w_ovf;

    // Operation[2] selects subtract: invert B and inject the carry-in.
    assign w_b_eff = Operation[2] ? ~B : B;
    assign w_sum   = 4'(A + w_b_eff + {3'b000, Operation[2]});
    assign w_ovf   = (A[3] == w_b_eff[3]) && (w_sum[3] != A[3]);

    always_comb begin
        Result   = 4'b0000;
        Overflow = 1'b0;
        case (Operation)
            3'b000: Result = A & B;
            3'b001: Result = A | B;
            3'b010: begin
                Result   = w_sum;
                Overflow = w_ovf;
            end
            3'b110: begin
                Result   = w_sum;
                Overflow = w_ovf;
            end
            3'b111: begin
                Result   = {3'b000, w_sum[3] ^ w_ovf};
                Overflow = w_ovf;
            end
            default: begin
                Result   = 4'b0000;
                Overflow = 1'b0;
            end
        endcase
    end

    assign Zero = (Result == 4'b0000);

endmodule
`default_nettype wire

// File: rtl/alu_cmd_engine.sv
`default_nettype none
//==============================================================================
// Module : alu_cmd_engine
// Brief  : Valid/ready command FIFO in front of alu_4bit with a registered,
//          back-pressurable response slot and a saturating overflow counter.
// Rev    : 1.0 - initial release
//==============================================================================
module alu_cmd_engine #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_result,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic             rsp_illegal,
    output logic [CNT_W-1:0] ovf_count,
    output logic             busy
);

    import alu_pkg::*;

    localparam int                 c_ptr_w   = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_depth   = (c_ptr_w + 1)'(DEPTH);
    localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [CNT_W-1:0]   c_ovf_one = CNT_W'(1);

    alu_cmd_t           r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    logic               r_rsp_valid;
    logic [3:0]         r_rsp_result;
    logic               r_rsp_zero;
    logic               r_rsp_overflow;
    logic               r_rsp_illegal;
    logic [CNT_W-1:0]   r_ovf_count;

    alu_cmd_t           w_cmd_in;
    alu_cmd_t           w_head;
    logic               w_push;
    logic               w_load;
    logic               w_head_legal;
    logic [3:0]         w_alu_result;
    logic               w_alu_zero;
    logic               w_alu_ovf;
    logic [3:0]         w_ld_result;
    logic               w_ld_zero;
    logic               w_ld_ovf;

    assign w_cmd_in  = '{op: cmd_op, a: cmd_a, b: cmd_b};
    assign w_head    = r_mem[r_rd_ptr];
    assign cmd_ready = (r_count < c_depth);
    assign w_push    = cmd_valid && cmd_ready;
    assign w_load    = (r_count != '0) && (!r_rsp_valid || rsp_ready);

    alu_4bit u_alu (
        .A         (w_head.a),
        .B         (w_head.b),
        .Operation (w_head.op),
        .Result    (w_alu_result),
        .Zero      (w_alu_zero),
        .Overflow  (w_alu_ovf)
    );

    // Illegal opcodes still flow through in order but report a clean zero result.
    assign w_head_legal = is_legal_op(w_head.op);
    assign w_ld_result  = w_head_legal ? w_alu_result : 4'b0000;
    assign w_ld_zero    = w_head_legal ? w_alu_zero   : 1'b1;
    assign w_ld_ovf     = w_head_legal && w_alu_ovf;

    always_ff @(posedge clk) begin
        if (w_push && !clr) begin
            r_mem[r_wr_ptr] <= w_cmd_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_result   <= 4'b0000;
            r_rsp_zero     <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_rsp_illegal  <= 1'b0;
            r_ovf_count    <= '0;
        end else if (clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rsp_valid <= 1'b0;
            r_ovf_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push && !w_load) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_push && w_load) begin
                r_count <= r_count - c_cnt_one;
            end

            if (w_load) begin
                r_rsp_valid    <= 1'b1;
                r_rsp_result   <= w_ld_result;
                r_rsp_zero     <= w_ld_zero;
                r_rsp_overflow <= w_ld_ovf;
                r_rsp_illegal  <= !w_head_legal;
                if (w_ld_ovf && (r_ovf_count != '1)) begin
                    r_ovf_count <= r_ovf_count + c_ovf_one;
                end
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_result   = r_rsp_result;
    assign rsp_zero     = r_rsp_zero;
    assign rsp_overflow = r_rsp_overflow;
    assign rsp_illegal  = r_rsp_illegal;
    assign ovf_count    = r_ovf_count;
    assign busy         = (r_count != '0) || r_rsp_valid;

endmodule
`default_nettype wire

// File: doc/alu_cmd_engine.md
# alu_cmd_engine

Command-driven front end for the `alu_4bit` datapath. It accepts ALU commands (`op`, `a`, `b`) over a valid/ready port and buffers them in a small FIFO. It issues one command per cycle to an `alu_4bit` instance and returns the registered `Result`/`Zero`/`Overflow` over a second valid/ready port. This lets a sequential controller or bus bridge drive the ALU as a pipelined responder instead of wiring it combinationally.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `CNT_W`, 8: width of the saturating overflow counter.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous flush: empties FIFO, drops response, zeroes counter.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO can accept; equals `count < DEPTH`.
- `cmd_op`  in  3  opcode. Legal values: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `cmd_a`, `cmd_b`  in  4 each  signed two's-complement operands.
- `rsp_valid`  out  1  response register holds data.
- `rsp_ready`  in  1  consumer takes response.
- `rsp_result`  out  4  ALU result.
- `rsp_zero`  out  1  result == 0.
- `rsp_overflow`  out  1  signed overflow of ADD/SUB; for SLT, the A−B overflow.
- `rsp_illegal`  out  1  opcode was not legal.
- `ovf_count`  out  CNT_W  responses loaded with overflow=1; saturating.
- `busy`  out  1  `count != 0 || rsp_valid`.

## Operation
- Push: `cmd_valid && cmd_ready` at an edge writes {op,a,b} to the FIFO tail.
- The FIFO head drives `alu_4bit` (A, B, Operation) combinationally.
- Load condition: FIFO non-empty and (`!rsp_valid || rsp_ready`). At that edge the engine pops the head and loads its ALU outputs into the rsp_* registers, and sets `rsp_valid`.
- If the FIFO is empty and `rsp_valid && rsp_ready`, `rsp_valid` clears.
- Push and pop may occur in the same cycle; `count` is then unchanged.
- Push while full cannot occur, because `cmd_ready` is low.
- ALU semantics:
  - AND and OR are bitwise.
  - ADD/SUB wrap mod 16; overflow = operand signs agree (B inverted for SUB) and result sign differs.
  - SLT result = 0001 if A<B signed, computed as sign(A−B) XOR overflow; otherwise 0000.
- Illegal opcode (011, 100, 101) is still popped in order. The response carries `rsp_result`=0, `rsp_zero`=1, `rsp_overflow`=0, `rsp_illegal`=1.
- `ovf_count` increments on each load with overflow=1 and holds at all-ones.
- `clr` has priority over push/pop in the same cycle:
  - count→0, `rsp_valid`→0, `ovf_count`→0.
  - A simultaneous push is discarded.
- Ordering is strict FIFO; no command is dropped or duplicated except by `clr` or reset.

## Timing
- Reset (asserted asynchronously, released synchronously by the integrator):
  - FIFO empty, `rsp_valid`=0, `rsp_result`=0, `rsp_zero`=0, `rsp_overflow`=0, `rsp_illegal`=0, `ovf_count`=0.
  - `busy`=0, `cmd_ready`=1.
- Latency: a command pushed at edge k into an empty FIFO with the response slot free shows `rsp_valid`=1 after edge k+1.
- Throughput: one response per cycle with `rsp_ready` held high and `cmd_valid` held high.
- Backpressure:
  - `rsp_ready` low holds all rsp_* outputs stable while `rsp_valid`=1.
  - The FIFO fills; `cmd_ready` falls after the DEPTH-th un-popped push.
- Full with a pop: `cmd_ready` is 0 during that cycle and rises the cycle after.
- Reset mid-stream: all in-flight commands and the pending response are lost immediately; no response emerges after release.

## Structure
- Shared package `alu_pkg`:
  - opcode constants `OP_AND`, `OP_OR`, `OP_ADD`, `OP_SUB`, `OP_SLT`;
  - function `is_legal_op`;
  - command struct {op,a,b} (11 bits).
- Sub-module: one `alu_4bit` instance, unchanged, with named port connections (A, B, Operation, Result, Zero, Overflow).
- FIFO is inline: pointers of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits. Illegal-op masking is applied at the load mux.

## Test plan
- Single ADD 0101+0001, `rsp_ready`=1 → after 2 edges rsp_result=0110, zero=0, overflow=0, illegal=0.
- Back-to-back stream, both handshakes high: ADD 0111+0001, SUB 1110−0111, SLT 1101 vs 0110 → responses 1000/ovf=1, 0111/ovf=1, 0001/ovf=1 (−3<6), on consecutive cycles; ovf_count=3.
- `rsp_ready` low; push 5 commands with DEPTH=4 → the first loads into the response register, the next 4 fill the FIFO, `cmd_ready`=0. The 6th offer stalls. Outputs are stable until `rsp_ready` rises; then drain in order.
- Opcode 100 with a=0101, b=0010 → rsp_result=0000, zero=1, overflow=0, illegal=1; neighbouring commands unaffected.
- `clr` pulsed with 3 commands queued and a simultaneous push → next cycle `busy`=0, `rsp_valid`=0, `ovf_count`=0, `cmd_ready`=1; no stale response appears afterwards.
- `rst_n` dropped asynchronously mid-stream while `rsp_valid`=1 → outputs go to reset values before the next edge; 256 overflowing ADDs after release → ovf_count saturates at 255.
